// File: rtl/result_serializer_if.sv
// Byte-stream bus of result_serializer: wide capture input plus addressed
// byte output with a valid/ready handshake.
interface result_serializer_if #(
  parameter int NUM_BYTES = 16,
  parameter int ADDR_W    = 6
);
  logic                   load;
  logic [8*NUM_BYTES-1:0] data_in;
  logic [7:0]             out_data;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;

  // master drives the capture request and consumes bytes
  modport master (
    output load, data_in, out_ready,
    input  out_data, out_addr, out_valid, busy, done
  );

  // slave is the serializer itself
  modport slave (
    input  load, data_in, out_ready,
    output out_data, out_addr, out_valid, busy, done
  );
endinterface

// File: rtl/result_serializer.sv
// Captures a NUM_BYTES result vector and streams it out one addressed byte per
// handshake. RESULT_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte at addr NUM_BYTES.
module result_serializer #(
  parameter int NUM_BYTES = 16,
  parameter int ADDR_W    = 6
) (
  input logic               clk,
  input logic               rst,
  result_serializer_if.slave bus
);

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             idx_q, idx_d;
  logic [NUM_BYTES-1:0][7:0]     buf_q, buf_d;
  logic [7:0]                    byte_sel;
  logic                          hs;
  logic                          valid_q, busy_q, done_q, done_d;
  logic [7:0]                    data_q, data_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  logic [7:0]                    csum_q, csum_d;
`endif

  assign hs = valid_q & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    done_d   = 1'b0;
    byte_sel = 8'h00;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: if (bus.load) begin
        buf_d   = bus.data_in;
        idx_d   = '0;
        state_d = SEND;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
        csum_d  = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) csum_d = csum_d ^ bus.data_in[8*i +: 8];
`endif
      end
      SEND: if (hs) begin
        if (idx_q == ADDR_W'(NUM_BYTES-1)) begin
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
      CSUM: if (hs) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // outputs are precomputed from the next state so they leave a register
    for (int i = 0; i < NUM_BYTES; i++)
      if (idx_d == ADDR_W'(i)) byte_sel = buf_d[i];
    data_d = 8'h00;
    addr_d = '0;
    if (state_d == SEND) begin
      data_d = byte_sel;
      addr_d = idx_d;
    end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    if (state_d == CSUM) begin
      data_d = csum_d;
      addr_d = ADDR_W'(NUM_BYTES);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 8'h00;
      addr_q  <= '0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      valid_q <= (state_d != IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_data  = data_q;
  assign bus.out_addr  = addr_q;

endmodule

// File: tb/tb_result_serializer.sv
// Randomized and directed bench for result_serializer against a queue-based
// transaction model of the addressed byte stream.
module tb_result_serializer;
  localparam int NB = 16;
  localparam int AW = 6;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct {
    logic [7:0]    d;
    logic [AW-1:0] a;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_serializer_if #(.NUM_BYTES(NB), .ADDR_W(AW)) bus ();
  result_serializer #(.NUM_BYTES(NB), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  item_t q[$];
  bit m_done = 1'b0;
  logic [8*NB-1:0] vec_a = 128'h00112233445566778899AABBCCDDEEFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one transaction = every byte in ascending address order, then the checksum
  task automatic push_vec(input logic [8*NB-1:0] v);
    item_t it;
    logic [7:0] cs = 8'h00;
    for (int i = 0; i < NB; i++) begin
      it.d = v[8*i +: 8];
      it.a = AW'(i);
      cs ^= it.d;
      q.push_back(it);
    end
    if (CS) begin
      it.d = cs;
      it.a = AW'(NB);
      q.push_back(it);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (q.size() > 0) begin
        if (bus.out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) m_done = 1'b1;
        end
      end else if (bus.load) begin
        push_vec(bus.data_in);
      end
    end
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("busy", 32'(bus.busy), 32'(q.size() > 0));
    check("done", 32'(bus.done), 32'(m_done));
    if (q.size() > 0) begin
      check("out_data", 32'(bus.out_data), 32'(q[0].d));
      check("out_addr", 32'(bus.out_addr), 32'(q[0].a));
    end
  endtask

  task automatic start(input logic [8*NB-1:0] v);
    bus.load = 1'b1;
    bus.data_in = v;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    logic [8*NB-1:0] v;
    rst = 1'b1;
    bus.load = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_data", 32'(bus.out_data), 32'h0);
    check("rst_addr", 32'(bus.out_addr), 32'h0);
    rst = 1'b0;
    tick();

    // basic stream
    bus.out_ready = 1'b1;
    start(vec_a);
    check("first_byte", 32'(bus.out_data), 32'hFF);
    repeat (20) tick();

    // backpressure on odd cycles
    start(vec_a);
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = (c % 2 == 0);
      tick();
    end

    // load while busy is ignored
    bus.out_ready = 1'b1;
    start(vec_a);
    repeat (5) tick();
    check("idx5_addr", 32'(bus.out_addr), 32'd5);
    bus.load = 1'b1;
    bus.data_in = '1;
    tick();
    bus.load = 1'b0;
    repeat (18) tick();

    // reset after byte 7 accepted
    start(vec_a);
    repeat (8) tick();
    check("pre_rst_addr", 32'(bus.out_addr), 32'd8);
    rst = 1'b1;
    tick();
    check("midrst_data", 32'(bus.out_data), 32'h0);
    check("midrst_addr", 32'(bus.out_addr), 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    start(vec_a);
    check("restart_addr", 32'(bus.out_addr), 32'h0);
    repeat (20) tick();

    // back-to-back: load in the done cycle
    start(vec_a);
    for (int c = 0; c < 40 && !m_done; c++) tick();
    check("b2b_done", 32'(bus.done), 32'h1);
    v = {$urandom, $urandom, $urandom, $urandom};
    start(v);
    check("b2b_byte0", 32'(bus.out_data), 32'(v[7:0]));
    repeat (20) tick();

    // checksum pattern (plain stream when the feature is absent)
    v = '0;
    v[7:0] = 8'hA5;
    v[31:24] = 8'h0F;
    start(v);
    repeat (NB) tick();
    if (CS) begin
      check("csum_data", 32'(bus.out_data), 32'hAA);
      check("csum_addr", 32'(bus.out_addr), 32'(NB));
    end
    repeat (4) tick();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom % 80 == 0);
      bus.load = ($urandom % 4 == 0);
      bus.data_in = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = ($urandom % 3 != 0);
      tick();
    end
    rst = 1'b0;
    bus.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
